intr_rr_scheduler: RTL
======================

# intr_rr_scheduler

Round-robin interrupt scheduler that latches requests from NINTR sources into a pending register and grants the shared interrupt service path to one source at a time. It raises a one-hot `ack` and `irq` for the winner, then holds the grant until the handler signals `done` or a service timeout expires. Fairness comes from a rotating priority pointer. The block sits between peripheral request lines and the CPU interrupt input, in the same role as the fixed-priority interrupt controller.

## Interface
- `NINTR`, 4: number of interrupt sources, ≥2.
- `TIMEOUT`, 16: maximum SERVICE cycles before a grant is force-released, ≥2.
- `IDW`, `$clog2(NINTR)`: width of `id`. Derived; not overridden.
- `clk` in 1: single clock; everything is posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req` in NINTR: request lines. A 1 in any cycle sets the matching pending bit.
- `mask` in NINTR: 1 = source enabled for arbitration. Masked requests stay pending.
- `done` in 1: handler completion. Sampled only in SERVICE.
- `ack` out NINTR: one-hot grant. All zero when no grant is active.
- `irq` out 1: interrupt to CPU. High exactly while `ack` is non-zero.
- `id` out IDW: index of the granted source. Holds its last value when `irq` is 0.
- `timeout_err` out 1: one-cycle pulse when a grant is force-released.

## Operation
- **Reset values:** `ack`=0, `irq`=0, `id`=0, `timeout_err`=0, pending=0, ptr=0, counter=0, state=IDLE.
- **Pending update, every cycle:** pending_next = (pending & ~clr) | req. clr is one-hot of the winner on the grant edge, otherwise 0. req wins over clr for the same bit, so that bit stays pending.
- **Eligible set:** pending & mask.
- **Winner:** the first set bit of the eligible set, searching upward from index ptr and wrapping modulo NINTR.
- **FSM states:** IDLE, SERVICE, RELEASE.
  - **IDLE:** if the eligible set is non-zero, go to SERVICE. On that edge: `ack`=1<<winner, `irq`=1, `id`=winner, pending[winner] cleared, counter=0.
  - **SERVICE:** counter increments every cycle.
    - If `done`=1: go to RELEASE; `ack`=0, `irq`=0; ptr=(id+1) mod NINTR.
    - Else if counter==TIMEOUT-1: go to RELEASE; `ack`=0, `irq`=0; `timeout_err`=1 for one cycle; ptr=(id+1) mod NINTR.
    - If `done` and the timeout coincide, `done` wins and no error is raised.
  - **RELEASE:** one dead cycle, then IDLE unconditionally.
  - **Illegal encoding:** recover to IDLE with outputs cleared.
- **Grant stability:** a mask change during SERVICE does not revoke the current grant. `done` outside SERVICE is ignored.
- **Counter width:** $clog2(TIMEOUT) bits. It never wraps, because the timeout exits SERVICE first.
- **Asynchronous reset mid-SERVICE:** all state clears immediately and in-flight pending requests are lost.

## Timing
- **Grant latency:** a req sampled high at edge k in IDLE (enabled, no contention) sets pending at edge k. `ack`/`irq` rise at edge k+1.
- **Release:** `done` high at edge k in SERVICE drops `ack` at edge k. IDLE is entered at edge k+1, and the earliest next grant is at edge k+2.
- **Minimum grant:** the minimum grant length is 1 cycle (`done` at the first SERVICE edge).
- **Timeout:** with no `done`, `ack` is high for exactly TIMEOUT cycles. `timeout_err` is high during the first RELEASE cycle.
- **Outputs:** all outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- **Package `intr_pkg`:** state encoding localparams (one-hot: IDLE=3'b001, SERVICE=3'b010, RELEASE=3'b100) and the default NINTR/TIMEOUT constants, shared with the fixed-priority controller.
- **Sub-module `rr_priority_pick`:** combinational. Inputs are `vec` [NINTR] and `ptr` [IDW]. Outputs are `idx` [IDW] and `valid`. It rotates `vec` right by ptr, priority-encodes the lowest set bit, and adds ptr back modulo NINTR. `valid` = (vec != 0).
- **Top level:** pending register, ptr, counter, FSM and output registers live in the top.

## Test plan
- **Reset:** hold reset_n=0 with req=4'b1111. Require all outputs 0. After release with mask=4'b1111, require the first grant to be `ack`=4'b0001, `id`=0.
- **Round-robin rotation:** hold req=4'b1111 and mask=4'b1111, and pulse `done` one cycle after each grant. Require the grant order to be ids 0,1,2,3,0, with each new `ack` exactly 2 cycles after the previous `done`.
- **Masking:** set req=4'b0100 with mask=4'b1011. Require no `irq`. Raise mask[2]. Require `ack`=4'b0100 one cycle later.
- **Timeout:** with TIMEOUT=16, req=4'b0010, and `done` never asserted, require `ack` high for 16 cycles, then `timeout_err` as a single-cycle pulse, then ptr=2.
- **Re-request during grant:** hold req[1] high through a grant to source 1. Require source 1 to be granted again after release if no other source is eligible.
- **Reset mid-operation:** assert reset_n=0 in the middle of SERVICE. Require `ack`, `irq` and pending to clear asynchronously, with no grant until a new req arrives.

Source files
------------

// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt controllers: FSM state encoding
// and default sizing constants.
package intr_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'b001;
  localparam state_t ST_SERVICE = 3'b010;
  localparam state_t ST_RELEASE = 3'b100;

  localparam int unsigned NINTR_DEF   = 4;
  localparam int unsigned TIMEOUT_DEF = 16;

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority picker: first set bit of vec searching upward from ptr,
// wrapping modulo NINTR.
module rr_priority_pick
  import intr_pkg::*;
#(
  parameter  int unsigned NINTR = NINTR_DEF,
  localparam int unsigned IDW   = $clog2(NINTR)
) (
  input  logic [NINTR-1:0] vec,
  input  logic [IDW-1:0]   ptr,
  output logic [IDW-1:0]   idx,
  output logic             valid
);

  logic [NINTR-1:0] rot;
  logic [IDW-1:0]   src;
  logic [IDW-1:0]   off;
  logic             found;

  always_comb begin
    rot   = '0;
    src   = '0;
    off   = '0;
    found = 1'b0;
    // rot[0] is the source at ptr, so the lowest set bit of rot is the winner
    for (int i = 0; i < int'(NINTR); i++) begin
      src    = IDW'((i + int'(ptr)) % int'(NINTR));
      rot[i] = vec[src];
    end
    for (int i = 0; i < int'(NINTR); i++) begin
      if (!found && rot[i]) begin
        off   = IDW'(i);
        found = 1'b1;
      end
    end
    idx   = IDW'((int'(off) + int'(ptr)) % int'(NINTR));
    valid = |vec;
  end

endmodule

// File: rtl/intr_rr_scheduler.sv
// Round-robin interrupt scheduler: latches requests, grants one source at a
// time, and holds the grant until done or service timeout.
//
//   state   | meaning
//   IDLE    | no grant; grant winner as soon as any eligible request exists
//   SERVICE | grant active; wait for done or timeout
//   RELEASE | one dead cycle after a grant ends
module intr_rr_scheduler
  import intr_pkg::*;
#(
  parameter  int unsigned NINTR   = NINTR_DEF,
  parameter  int unsigned TIMEOUT = TIMEOUT_DEF,
  localparam int unsigned IDW     = $clog2(NINTR),
  localparam int unsigned CW      = $clog2(TIMEOUT)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NINTR-1:0] req,
  input  logic [NINTR-1:0] mask,
  input  logic             done,
  output logic [NINTR-1:0] ack,
  output logic             irq,
  output logic [IDW-1:0]   id,
  output logic             timeout_err
);

  state_t           state_q, state_d;
  logic [NINTR-1:0] pend_q, pend_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NINTR-1:0] ack_q, ack_d;
  logic             irq_q, irq_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             terr_q, terr_d;

  logic [NINTR-1:0] clr;
  logic [IDW-1:0]   win_idx;
  logic             win_valid;
  logic             timeout_hit;
  logic [IDW-1:0]   ptr_after;

  rr_priority_pick #(.NINTR(NINTR)) u_pick (
    .vec   (pend_q & mask),
    .ptr   (ptr_q),
    .idx   (win_idx),
    .valid (win_valid)
  );

  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
  assign ptr_after   = (id_q == IDW'(NINTR - 1)) ? '0 : id_q + IDW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      irq_q   <= 1'b0;
      id_q    <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      irq_q   <= irq_d;
      id_q    <= id_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:    state_d = win_valid ? ST_SERVICE : ST_IDLE;
      ST_SERVICE: state_d = (done || timeout_hit) ? ST_RELEASE : ST_SERVICE;
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ack_d  = ack_q;
    irq_d  = irq_q;
    id_d   = id_q;
    terr_d = 1'b0;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    clr    = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          ack_d          = '0;
          ack_d[win_idx] = 1'b1;
          irq_d          = 1'b1;
          id_d           = win_idx;
          clr[win_idx]   = 1'b1;
          cnt_d          = '0;
        end
      end
      ST_SERVICE: begin
        // done takes precedence over a coincident timeout
        if (done || timeout_hit) begin
          ack_d  = '0;
          irq_d  = 1'b0;
          ptr_d  = ptr_after;
          terr_d = !done;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RELEASE: ;
      default: begin
        ack_d = '0;
        irq_d = 1'b0;
        id_d  = '0;
      end
    endcase
  end

  assign pend_d = (pend_q & ~clr) | req;

  assign ack         = ack_q;
  assign irq         = irq_q;
  assign id          = id_q;
  assign timeout_err = terr_q;

endmodule
